// File: rtl/arcade_score_tracker.sv
// Binary Arcade score tracker: counts hits and misses, tracks hit streaks, and
// runs a restartable game that ends in WIN or LOSE.
module arcade_score_tracker #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned WIN_SCORE  = 10,
  parameter int unsigned MAX_MISSES = 5,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned MISS_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              guess_valid,
  input  logic [DATA_W-1:0] user_input,
  input  logic [DATA_W-1:0] random_number,
  output logic              guess_ready,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic [SCORE_W-1:0] streak,
  output logic [SCORE_W-1:0] best_streak,
  output logic              hit,
  output logic              miss,
  output logic [1:0]        state,
  output logic              win,
  output logic              lose
);

  localparam logic [SCORE_W-1:0] WIN_LIMIT  = SCORE_W'(WIN_SCORE);
  localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic [SCORE_W-1:0] streak_q, streak_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic               accept;
  logic               match;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] streak_inc;
  logic [MISS_W-1:0]  misses_inc;

  assign accept     = guess_valid && (state_q == ST_PLAY) && !start;
  assign match      = (user_input == random_number);
  assign score_inc  = score_q + SCORE_W'(1);
  assign streak_inc = streak_q + SCORE_W'(1);
  assign misses_inc = misses_q + MISS_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next counter values; start outranks any concurrent guess
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    misses_d = misses_q;
    streak_d = streak_q;
    best_d   = best_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (start) begin
      state_d  = ST_PLAY;
      score_d  = '0;
      misses_d = '0;
      streak_d = '0;
    end else if (accept) begin
      if (match) begin
        score_d  = score_inc;
        streak_d = streak_inc;
        best_d   = (streak_inc > best_q) ? streak_inc : best_q;
        hit_d    = 1'b1;
        if (score_inc == WIN_LIMIT) state_d = ST_WIN;
      end else begin
        misses_d = misses_inc;
        streak_d = '0;
        miss_d   = 1'b1;
        if (misses_inc == MISS_LIMIT) state_d = ST_LOSE;
      end
    end
  end

  // Counter and pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q  <= '0;
      misses_q <= '0;
      streak_q <= '0;
      best_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      score_q  <= score_d;
      misses_q <= misses_d;
      streak_q <= streak_d;
      best_q   <= best_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign state       = state_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign streak      = streak_q;
  assign best_streak = best_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign guess_ready = (state_q == ST_PLAY);
  assign win         = (state_q == ST_WIN);
  assign lose        = (state_q == ST_LOSE);

endmodule

// File: tb/tb_arcade_score_tracker.sv
// Directed bench for arcade_score_tracker: default instance plus an 8-bit,
// short-game instance, checked with immediate assertions.
module tb_arcade_score_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default-parameter instance
  logic       d_start, d_valid;
  logic [3:0] d_ui, d_rn;
  logic       d_ready, d_hit, d_miss, d_win, d_lose;
  logic [3:0] d_score, d_streak, d_best;
  logic [2:0] d_misses;
  logic [1:0] d_state;

  arcade_score_tracker dut_d (
    .clk(clk), .reset(reset), .start(d_start), .guess_valid(d_valid),
    .user_input(d_ui), .random_number(d_rn), .guess_ready(d_ready),
    .score(d_score), .misses(d_misses), .streak(d_streak),
    .best_streak(d_best), .hit(d_hit), .miss(d_miss), .state(d_state),
    .win(d_win), .lose(d_lose)
  );

  // Overridden instance: 8-bit data, win at 3, lose at 2
  logic       p_start, p_valid;
  logic [7:0] p_ui, p_rn;
  logic       p_ready, p_hit, p_miss, p_win, p_lose;
  logic [3:0] p_score, p_streak, p_best;
  logic [2:0] p_misses;
  logic [1:0] p_state;

  arcade_score_tracker #(.DATA_W(8), .WIN_SCORE(3), .MAX_MISSES(2)) dut_p (
    .clk(clk), .reset(reset), .start(p_start), .guess_valid(p_valid),
    .user_input(p_ui), .random_number(p_rn), .guess_ready(p_ready),
    .score(p_score), .misses(p_misses), .streak(p_streak),
    .best_streak(p_best), .hit(p_hit), .miss(p_miss), .state(p_state),
    .win(p_win), .lose(p_lose)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    d_start = 0; d_valid = 0; d_ui = 0; d_rn = 0;
    p_start = 0; p_valid = 0; p_ui = 0; p_rn = 0;
    tick(); tick();
    check("rst_state", 32'(d_state), 32'd0);
    check("rst_score", 32'(d_score), 32'd0);
    check("rst_ready", 32'(d_ready), 32'd0);
    check("rst_winlose", 32'({d_win, d_lose, d_hit, d_miss}), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_state", 32'(d_state), 32'd0);

    // Ten matching guesses reach WIN
    d_start = 1; tick(); d_start = 0;
    check("play_state", 32'(d_state), 32'd1);
    check("play_ready", 32'(d_ready), 32'd1);
    d_valid = 1; d_ui = 4'b0110; d_rn = 4'b0110;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("win_score%0d", i), 32'(d_score), 32'(i));
      check($sformatf("win_hit%0d", i), 32'({d_hit, d_miss}), 32'b10);
    end
    check("win_state", 32'(d_state), 32'd2);
    check("win_flag", 32'(d_win), 32'd1);
    check("win_ready", 32'(d_ready), 32'd0);
    tick();
    check("win_11th_score", 32'(d_score), 32'd10);
    check("win_11th_hit", 32'(d_hit), 32'd0);
    check("win_hold", 32'(d_state), 32'd2);
    check("win_best", 32'(d_best), 32'd10);

    // Five misses reach LOSE
    d_valid = 0; d_start = 1; tick(); d_start = 0;
    check("restart_score", 32'(d_score), 32'd0);
    check("restart_best", 32'(d_best), 32'd10);
    d_valid = 1; d_ui = 4'd3; d_rn = 4'd5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("lose_misses%0d", i), 32'(d_misses), 32'(i));
      check($sformatf("lose_miss%0d", i), 32'({d_hit, d_miss}), 32'b01);
    end
    check("lose_state", 32'(d_state), 32'd3);
    check("lose_flag", 32'(d_lose), 32'd1);
    check("lose_score", 32'(d_score), 32'd0);
    tick();
    check("lose_hold", 32'(d_state), 32'd3);
    check("lose_nopulse", 32'(d_miss), 32'd0);

    // Streak tracking: H H H M H H (reset first so best_streak starts at 0)
    d_valid = 0;
    reset = 0; #1 reset = 1;
    d_start = 1; tick(); d_start = 0;
    d_valid = 1; d_rn = 4'd9;
    d_ui = 4'd9; tick(); check("streak1", 32'(d_streak), 32'd1);
    tick(); check("streak2", 32'(d_streak), 32'd2);
    tick(); check("streak3", 32'(d_streak), 32'd3);
    d_ui = 4'd8; tick(); check("streak0", 32'(d_streak), 32'd0);
    check("streak_miss_pulse", 32'({d_hit, d_miss}), 32'b01);
    d_ui = 4'd9; tick(); check("streak1b", 32'(d_streak), 32'd1);
    tick(); check("streak2b", 32'(d_streak), 32'd2);
    check("streak_best", 32'(d_best), 32'd3);
    check("streak_score", 32'(d_score), 32'd5);
    check("streak_misses", 32'(d_misses), 32'd1);
    d_valid = 0; tick();
    check("idle_cycle_pulses", 32'({d_hit, d_miss}), 32'b00);
    d_start = 1; tick(); d_start = 0;
    check("restart_clear", 32'({d_score, d_streak, 1'b0, d_misses}), 32'd0);
    check("restart_keep_best", 32'(d_best), 32'd3);

    // Reach score 6, then assert reset between edges
    d_valid = 1; d_ui = 4'd2; d_rn = 4'd2;
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_score", 32'(d_score), 32'd6);
    #2 reset = 0;
    #1;
    check("async_state", 32'(d_state), 32'd0);
    check("async_counts", 32'({d_score, d_streak, d_best, d_misses}), 32'd0);
    check("async_flags", 32'({d_ready, d_win, d_lose, d_hit, d_miss}), 32'd0);
    tick();
    reset = 1;

    // Guesses ignored in IDLE
    tick(); tick();
    check("idle_guess_score", 32'(d_score), 32'd0);
    check("idle_guess_hit", 32'(d_hit), 32'd0);
    check("idle_guess_state", 32'(d_state), 32'd0);

    // start with a matching guess: guess dropped, held start keeps clearing
    d_start = 1; tick();
    check("start_drop_state", 32'(d_state), 32'd1);
    check("start_drop_hit", 32'(d_hit), 32'd0);
    check("start_drop_score", 32'(d_score), 32'd0);
    tick();
    check("start_held_score", 32'(d_score), 32'd0);
    check("start_held_hit", 32'(d_hit), 32'd0);
    d_start = 0; tick();
    check("after_start_score", 32'(d_score), 32'd1);
    check("after_start_hit", 32'(d_hit), 32'd1);
    d_valid = 0;

    // Overridden instance
    p_start = 1; tick(); p_start = 0;
    check("p_play", 32'(p_state), 32'd1);
    p_valid = 1; p_ui = 8'hA5; p_rn = 8'hA4; tick();
    check("p_a5a4_miss", 32'({p_hit, p_miss}), 32'b01);
    check("p_a5a4_misses", 32'(p_misses), 32'd1);
    check("p_a5a4_score", 32'(p_score), 32'd0);
    p_ui = 8'hFF; p_rn = 8'hFF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("p_score%0d", i), 32'(p_score), 32'(i));
    end
    check("p_win_state", 32'(p_state), 32'd2);
    check("p_win_flag", 32'(p_win), 32'd1);
    p_valid = 0; p_start = 1; tick(); p_start = 0;
    p_valid = 1; p_ui = 8'h00; p_rn = 8'h01;
    tick();
    check("p_miss1_state", 32'(p_state), 32'd1);
    tick();
    check("p_lose_state", 32'(p_state), 32'd3);
    check("p_lose_flag", 32'(p_lose), 32'd1);
    check("p_lose_misses", 32'(p_misses), 32'd2);
    check("p_best_kept", 32'(p_best), 32'd3);
    p_valid = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arcade_score_tracker.md
Name: arcade_score_tracker

Overview:
- Parametrised successor to the single-counter match scorer for the Binary Arcade game.
- Counts correct guesses (user_input == random_number) and wrong guesses.
- Tracks current and best hit streaks.
- Runs a game state machine that ends in WIN at a configurable score or LOSE at a configurable miss limit. It replaces simulation-terminating behaviour with status outputs and a restartable game.

Parameters:
DATA_W, 4, width of user_input and random_number
WIN_SCORE, 10, hits required to win (1..2^SCORE_W-1)
MAX_MISSES, 5, misses that cause a loss (1..2^MISS_W-1)
SCORE_W, 4, width of score, streak, best_streak
MISS_W, 3, width of misses

Ports:
clk  input  1  system clock, all state updates on rising edge only
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  start/restart game, sampled on rising edge
guess_valid  input  1  a guess is presented this cycle
user_input  input  DATA_W  player guess
random_number  input  DATA_W  target value for this guess
guess_ready  output  1  block accepts guesses (high only in PLAY)
score  output  SCORE_W  hits this game
misses  output  MISS_W  misses this game
streak  output  SCORE_W  consecutive hits, current run
best_streak  output  SCORE_W  longest run since reset
hit  output  1  one-cycle pulse: last accepted guess matched
miss  output  1  one-cycle pulse: last accepted guess did not match
state  output  2  0=IDLE, 1=PLAY, 2=WIN, 3=LOSE
win  output  1  high while state==WIN
lose  output  1  high while state==LOSE

Behaviour:
- Reset (reset==0, asynchronous, immediate):
  - state=IDLE.
  - score, misses, streak, best_streak, hit, miss = 0.
  - guess_ready, win, lose = 0.
  - Applies mid-game; all progress is lost, including best_streak.
- All outputs are registered. guess_ready, win and lose decode combinationally from the state register.
- Accept: a guess is accepted at a rising edge when guess_valid && guess_ready && !start. Guesses in IDLE/WIN/LOSE are ignored; they have no effect and no pulse.
- Accepted hit (user_input == random_number, full DATA_W compare):
  - score+=1, streak+=1, best_streak = max(best_streak, streak+1).
  - hit=1 for exactly the next cycle.
  - If score+1 == WIN_SCORE, state goes to WIN in the same edge.
- Accepted miss:
  - misses+=1, streak=0, best_streak unchanged.
  - miss=1 for exactly the next cycle.
  - If misses+1 == MAX_MISSES, state goes to LOSE in the same edge.
- Latency: counters, pulses and state all reflect a guess one cycle after the accepting edge.
- hit and miss are never both 1. Both are 0 on any cycle following an edge with no accepted guess.
- Back-to-back guesses are accepted every cycle while in PLAY. The guess completing the game is the last one accepted; guess_ready drops on the following cycle.
- start (any state):
  - Clears score, misses, streak, hit, miss; sets state=PLAY.
  - best_streak is kept.
  - start has priority over a simultaneous guess_valid; that guess is dropped.
  - start held high keeps re-clearing; guesses are accepted from the first edge after start deasserts.
- State transitions:
  - IDLE --start--> PLAY.
  - PLAY --winning hit--> WIN.
  - PLAY --losing miss--> LOSE.
  - PLAY --start--> PLAY (abort/restart).
  - WIN/LOSE --start--> PLAY.
  - WIN/LOSE hold indefinitely otherwise.
- Width rules:
  - Counters cannot wrap, because the game ends at WIN_SCORE/MAX_MISSES and both limits fit their widths.
  - Counter arithmetic is unsigned. Comparison against the limits uses the incremented value.
- No $finish or other simulation-control constructs; the block is synthesizable.

Test Plan:
- Reset then start, then 10 consecutive matching guesses (user_input=random_number=4'b0110), defaults:
  - score counts 1..10.
  - hit pulses on each of the 10 cycles.
  - state=WIN and win=1 one cycle after the 10th accepted guess.
  - guess_ready=0 afterwards; an 11th guess leaves score=10.
- Start, then 5 mismatching guesses (3 vs 5):
  - misses counts 1..5, miss pulses each cycle.
  - state=LOSE with lose=1, score=0.
- Start, then hit, hit, hit, miss, hit, hit:
  - streak follows 1,2,3,0,1,2.
  - best_streak=3, score=5, misses=1.
  - Then start: score=misses=streak=0, best_streak still 3.
- guess_valid=1 with matching data while in IDLE, and with start=1 in the same cycle as a match in PLAY:
  - No hit pulse; score remains 0.
- Assert reset=0 asynchronously mid-game (score=6, between clock edges):
  - All outputs are 0 and state=IDLE immediately, before the next clk edge.
  - After release, guesses are ignored until start.
- Parameter override DATA_W=8, WIN_SCORE=3, MAX_MISSES=2:
  - Guess 8'hA5 vs 8'hA4 counts as a miss.
  - Three 8'hFF matches reach WIN.
  - A fresh game with two misses reaches LOSE.
